fft_pair_feeder: RTL

//  Radix-2 DIF input stage that sits directly upstream of butterfly_fp.
//  - Accepts a serial stream of complex_fp_t samples, one N-point frame at a time.
//  - Buffers the first half of each frame (x[0..N/2-1]).
//  - While the second half arrives, emits the pairs (A=x[k], B=x[k+N/2]) with index k.
//  - Outputs drive butterfly_fp.A/.B/.enable; out_idx feeds twiddle lookup.

---
 rtl/fft_pair_feeder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fft_pair_feeder.sv
// Radix-2 DIF input stage: buffers the first half of each N-point frame.
// While the second half streams in, it emits (x[k], x[k+N/2], k) pairs to the butterfly.
module fft_pair_feeder #(
    parameter  int N     = 8,
    localparam int HALF  = N / 2,
    localparam int IDX_W = (N >= 4) ? $clog2(N / 2) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    input  logic             in_sof,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_a,
    output logic [63:0]      out_b,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             frame_err
);

    typedef enum logic {FILL, PAIR} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HALF - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [63:0]      out_a_q, out_a_d;
    logic [63:0]      out_b_q, out_b_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             out_last_q, out_last_d;
    logic             frame_err_q, frame_err_d;

    logic [63:0]      mem_q [HALF];
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;

    logic accept, cnt_last, sof_err;

    // FILL never stalls, so the next frame can load while the final pair is held.
    assign in_ready = (state_q == FILL) || !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign cnt_last = (cnt_q == LAST_IDX);
    assign sof_err  = accept && in_sof && ((state_q != FILL) || (cnt_q != '0));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        frame_err_d = sof_err;
        wr_en       = 1'b0;
        wr_addr     = cnt_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (sof_err) begin
            // Restart the frame with this sample as x[0]; a pending pair is left alone.
            wr_en   = 1'b1;
            wr_addr = '0;
            if (HALF == 1) begin
                cnt_d   = '0;
                state_d = PAIR;
            end else begin
                cnt_d   = IDX_W'(1);
                state_d = FILL;
            end
        end else if (accept) begin
            cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
            if (state_q == FILL) begin
                wr_en = 1'b1;
                if (cnt_last) begin
                    state_d = PAIR;
                end
            end else begin
                out_valid_d = 1'b1;
                out_a_d     = mem_q[cnt_q];
                out_b_d     = in_data;
                out_idx_d   = cnt_q;
                out_last_d  = cnt_last;
                if (cnt_last) begin
                    state_d = FILL;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= in_data;
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign frame_err = frame_err_q;

endmodule
